// File: rtl/pipe_ctrl_unit_if.sv
// Handshake bundle between the IF/ID front end and the pipelined control unit.
// The master drives the instruction and redirect; the slave returns stall/flush and the stage controls.
interface pipe_ctrl_unit_if #(parameter int REG_AW = 5);
    logic [31:0]       instr_i;
    logic              instr_valid_i;
    logic              redirect_i;
    logic              stall_o;
    logic              flush_o;
    logic [2:0]        ex_alu_op_o;
    logic              ex_alu_src_o;
    logic              ex_sign_o;
    logic              ex_branch_o;
    logic [1:0]        ex_branch_type_o;
    logic              ex_jump_o;
    logic              ex_jr_o;
    logic              ex_illegal_o;
    logic [REG_AW-1:0] ex_rs_o;
    logic [REG_AW-1:0] ex_rt_o;
    logic [REG_AW-1:0] ex_wreg_o;
    logic              ex_reg_write_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic              mem_reg_write_o;
    logic [REG_AW-1:0] mem_wreg_o;
    logic [1:0]        mem_mem_to_reg_o;
    logic              wb_reg_write_o;
    logic [REG_AW-1:0] wb_wreg_o;
    logic [1:0]        wb_mem_to_reg_o;

    modport master (
        output instr_i, instr_valid_i, redirect_i,
        input  stall_o, flush_o, ex_alu_op_o, ex_alu_src_o, ex_sign_o, ex_branch_o,
               ex_branch_type_o, ex_jump_o, ex_jr_o, ex_illegal_o, ex_rs_o, ex_rt_o,
               ex_wreg_o, ex_reg_write_o, mem_read_o, mem_write_o, mem_reg_write_o,
               mem_wreg_o, mem_mem_to_reg_o, wb_reg_write_o, wb_wreg_o, wb_mem_to_reg_o
    );
    modport slave (
        input  instr_i, instr_valid_i, redirect_i,
        output stall_o, flush_o, ex_alu_op_o, ex_alu_src_o, ex_sign_o, ex_branch_o,
               ex_branch_type_o, ex_jump_o, ex_jr_o, ex_illegal_o, ex_rs_o, ex_rt_o,
               ex_wreg_o, ex_reg_write_o, mem_read_o, mem_write_o, mem_reg_write_o,
               mem_wreg_o, mem_mem_to_reg_o, wb_reg_write_o, wb_wreg_o, wb_mem_to_reg_o
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers, flush and stall.
// Load-use detection is built only when PCU_HAZARD_EN is defined.
module pipe_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input logic             clk_i,
    input logic             rst_i,
    pipe_ctrl_unit_if.slave bus
);
    typedef struct packed {
        logic [2:0]        alu_op;
        logic              alu_src;
        logic              sign;
        logic              branch;
        logic [1:0]        branch_type;
        logic              jump;
        logic              jr;
        logic              illegal;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wreg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [1:0]        mem_to_reg;
    } ex_ctrl_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [REG_AW-1:0] wreg;
        logic [1:0]        mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic              reg_write;
        logic [REG_AW-1:0] wreg;
        logic [1:0]        mem_to_reg;
    } wb_ctrl_t;

    ex_ctrl_t  dec, id_ex;
    mem_ctrl_t ex_mem;
    wb_ctrl_t  mem_wb;
    logic [5:0] op, funct;
    logic [1:0] reg_dst;
    logic       hazard;
    logic       unused_bits;

    assign op          = bus.instr_i[31:26];
    assign funct       = bus.instr_i[5:0];
    assign unused_bits = ^bus.instr_i[10:6];

    always_comb begin
        dec         = '0;
        reg_dst     = 2'b00;
        dec.rs      = REG_AW'(bus.instr_i[25:21]);
        dec.rt      = REG_AW'(bus.instr_i[20:16]);
        case (op)
            6'd0: begin
                dec.sign  = 1'b1;
                reg_dst   = 2'b01;
                dec.jr    = (funct == 6'b001000);
                dec.reg_write = (funct != 6'b001000);
            end
            6'd8:  begin dec.alu_op = 3'b001; dec.reg_write = 1'b1; end
            6'd10: begin dec.alu_op = 3'b010; dec.sign = 1'b1; dec.reg_write = 1'b1; end
            6'd15: begin dec.alu_op = 3'b011; dec.sign = 1'b1; dec.reg_write = 1'b1; end
            6'd13: begin dec.alu_op = 3'b100; dec.reg_write = 1'b1; end
            6'd4:  begin dec.alu_op = 3'b110; dec.branch = 1'b1; dec.branch_type = 2'b00; end
            6'd5:  begin dec.alu_op = 3'b110; dec.branch = 1'b1; dec.branch_type = 2'b11; end
            6'd7:  begin dec.alu_op = 3'b110; dec.branch = 1'b1; dec.branch_type = 2'b01; end
            6'd1:  begin dec.alu_op = 3'b110; dec.branch = 1'b1; dec.branch_type = 2'b10; end
            6'd35: begin
                dec.alu_op = 3'b100; dec.sign = 1'b1; dec.reg_write = 1'b1;
                dec.mem_read = 1'b1; dec.mem_to_reg = 2'b01;
            end
            6'd43: begin dec.alu_op = 3'b100; dec.sign = 1'b1; dec.mem_write = 1'b1; end
            6'd2:  begin dec.alu_op = 3'b111; dec.jump = 1'b1; end
            6'd3:  begin
                dec.alu_op = 3'b111; dec.jump = 1'b1; dec.reg_write = 1'b1;
                reg_dst = 2'b10; dec.mem_to_reg = 2'b10;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.alu_src = !dec.illegal && (op[3] | op[5]);
        case (reg_dst)
            2'b01:   dec.wreg = REG_AW'(bus.instr_i[15:11]);
            2'b10:   dec.wreg = REG_AW'(LINK_REG);
            default: dec.wreg = REG_AW'(bus.instr_i[20:16]);
        endcase
        // $0 is hardwired, so a write to it is never a real write
        if (dec.wreg == '0) dec.reg_write = 1'b0;
    end

`ifdef PCU_HAZARD_EN
    logic reads_rt;
    assign reads_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) ||
                      (op == 6'd7) || (op == 6'd43);
    assign hazard   = id_ex.mem_read && (id_ex.wreg != '0) && bus.instr_valid_i &&
                      ((id_ex.wreg == dec.rs) || (reads_rt && id_ex.wreg == dec.rt));
`else
    assign hazard = 1'b0;
`endif

    assign bus.stall_o = hazard & !bus.redirect_i;
    assign bus.flush_o = bus.redirect_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= (bus.redirect_i || hazard || !bus.instr_valid_i) ? '0 : dec;
            ex_mem <= '{mem_read: id_ex.mem_read, mem_write: id_ex.mem_write,
                        reg_write: id_ex.reg_write, wreg: id_ex.wreg,
                        mem_to_reg: id_ex.mem_to_reg};
            mem_wb <= '{reg_write: ex_mem.reg_write, wreg: ex_mem.wreg,
                        mem_to_reg: ex_mem.mem_to_reg};
        end
    end

    assign bus.ex_alu_op_o      = id_ex.alu_op;
    assign bus.ex_alu_src_o     = id_ex.alu_src;
    assign bus.ex_sign_o        = id_ex.sign;
    assign bus.ex_branch_o      = id_ex.branch;
    assign bus.ex_branch_type_o = id_ex.branch_type;
    assign bus.ex_jump_o        = id_ex.jump;
    assign bus.ex_jr_o          = id_ex.jr;
    assign bus.ex_illegal_o     = id_ex.illegal;
    assign bus.ex_rs_o          = id_ex.rs;
    assign bus.ex_rt_o          = id_ex.rt;
    assign bus.ex_wreg_o        = id_ex.wreg;
    assign bus.ex_reg_write_o   = id_ex.reg_write;
    assign bus.mem_read_o       = ex_mem.mem_read;
    assign bus.mem_write_o      = ex_mem.mem_write;
    assign bus.mem_reg_write_o  = ex_mem.reg_write;
    assign bus.mem_wreg_o       = ex_mem.wreg;
    assign bus.mem_mem_to_reg_o = ex_mem.mem_to_reg;
    assign bus.wb_reg_write_o   = mem_wb.reg_write;
    assign bus.wb_wreg_o        = mem_wb.wreg;
    assign bus.wb_mem_to_reg_o  = mem_wb.mem_to_reg;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: opcode-table model with a three-slot stage array, checked every cycle,
// plus literal expectations for the directed scenarios. Hazard expectations follow PCU_HAZARD_EN.
module tb_pipe_ctrl_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.REG_AW(5)) bus ();
    pipe_ctrl_unit #(.REG_AW(5), .LINK_REG(31)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src, sign, branch;
        logic [1:0] btype;
        logic       jump, jr, illegal;
        logic [4:0] rs, rt, wreg;
        logic       reg_write, mem_read, mem_write;
        logic [1:0] m2r;
    } bun_t;

    bun_t stage [3];   // 0 = EX, 1 = MEM, 2 = WB
    int   checks = 0;
    int   failures = 0;
    logic last_stall, last_flush;

    function automatic bun_t spec_decode(input logic [31:0] ins);
        bun_t b = '0;
        int   dst = 0;   // 0 rt, 1 rd, 2 link
        logic [5:0] op = ins[31:26];
        b.rs = ins[25:21];
        b.rt = ins[20:16];
        case (op)
            0:  begin b.sign = 1; dst = 1;
                      if (ins[5:0] == 6'h08) b.jr = 1; else b.reg_write = 1; end
            8:  begin b.alu_op = 1; b.reg_write = 1; end
            10: begin b.alu_op = 2; b.sign = 1; b.reg_write = 1; end
            15: begin b.alu_op = 3; b.sign = 1; b.reg_write = 1; end
            13: begin b.alu_op = 4; b.reg_write = 1; end
            4:  begin b.alu_op = 6; b.branch = 1; b.btype = 0; end
            5:  begin b.alu_op = 6; b.branch = 1; b.btype = 3; end
            7:  begin b.alu_op = 6; b.branch = 1; b.btype = 1; end
            1:  begin b.alu_op = 6; b.branch = 1; b.btype = 2; end
            35: begin b.alu_op = 4; b.sign = 1; b.reg_write = 1; b.mem_read = 1; b.m2r = 1; end
            43: begin b.alu_op = 4; b.sign = 1; b.mem_write = 1; end
            2:  begin b.alu_op = 7; b.jump = 1; end
            3:  begin b.alu_op = 7; b.jump = 1; b.reg_write = 1; dst = 2; b.m2r = 2; end
            default: b.illegal = 1;
        endcase
        b.alu_src = op inside {8, 10, 13, 15, 35, 43};
        b.wreg = (dst == 1) ? ins[15:11] : (dst == 2) ? 5'd31 : ins[20:16];
        if (b.wreg == 0) b.reg_write = 0;
        return b;
    endfunction

    function automatic bit spec_hazard(input logic [31:0] ins, input logic valid);
`ifdef PCU_HAZARD_EN
        bit rt_read = ins[31:26] inside {0, 4, 5, 7, 43};
        return valid && stage[0].mem_read && stage[0].wreg != 0 &&
               (stage[0].wreg == ins[25:21] || (rt_read && stage[0].wreg == ins[20:16]));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(input bit exp_stall, input bit exp_flush);
        chk("stall", bus.stall_o, exp_stall);
        chk("flush", bus.flush_o, exp_flush);
        chk("ex_alu_op", bus.ex_alu_op_o, stage[0].alu_op);
        chk("ex_alu_src", bus.ex_alu_src_o, stage[0].alu_src);
        chk("ex_sign", bus.ex_sign_o, stage[0].sign);
        chk("ex_branch", bus.ex_branch_o, stage[0].branch);
        chk("ex_btype", bus.ex_branch_type_o, stage[0].btype);
        chk("ex_jump", bus.ex_jump_o, stage[0].jump);
        chk("ex_jr", bus.ex_jr_o, stage[0].jr);
        chk("ex_illegal", bus.ex_illegal_o, stage[0].illegal);
        chk("ex_rs", bus.ex_rs_o, stage[0].rs);
        chk("ex_rt", bus.ex_rt_o, stage[0].rt);
        chk("ex_wreg", bus.ex_wreg_o, stage[0].wreg);
        chk("ex_reg_write", bus.ex_reg_write_o, stage[0].reg_write);
        chk("mem_read", bus.mem_read_o, stage[1].mem_read);
        chk("mem_write", bus.mem_write_o, stage[1].mem_write);
        chk("mem_reg_write", bus.mem_reg_write_o, stage[1].reg_write);
        chk("mem_wreg", bus.mem_wreg_o, stage[1].wreg);
        chk("mem_m2r", bus.mem_mem_to_reg_o, stage[1].m2r);
        chk("wb_reg_write", bus.wb_reg_write_o, stage[2].reg_write);
        chk("wb_wreg", bus.wb_wreg_o, stage[2].wreg);
        chk("wb_m2r", bus.wb_mem_to_reg_o, stage[2].m2r);
    endtask

    // One cycle: apply inputs, check against the model, clock, advance the model.
    task automatic step(input logic [31:0] ins, input logic valid, input logic redir, input logic r);
        bit haz;
        bus.instr_i = ins; bus.instr_valid_i = valid; bus.redirect_i = redir; rst = r;
        #1;
        haz = spec_hazard(ins, valid);
        compare_all(haz && !redir, redir);
        last_stall = bus.stall_o;
        last_flush = bus.flush_o;
        @(posedge clk);
        if (r) begin
            stage[0] = '0; stage[1] = '0; stage[2] = '0;
        end else begin
            stage[2] = stage[1];
            stage[1] = stage[0];
            stage[0] = (redir || haz || !valid) ? '0 : spec_decode(ins);
        end
        #1;
    endtask

    logic [31:0] addi, lw9, lw0, add9, add0, addi9, jal, jr, ill, ins;
    logic [5:0] ops [15] = '{6'd0, 6'd8, 6'd10, 6'd15, 6'd13, 6'd4, 6'd5, 6'd7,
                             6'd1, 6'd35, 6'd43, 6'd2, 6'd3, 6'd63, 6'd6};
    logic [4:0] regs [5] = '{5'd0, 5'd1, 5'd2, 5'd9, 5'd31};

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom) : regs[$urandom_range(0, 4)];
    endfunction

    initial begin
        stage[0] = '0; stage[1] = '0; stage[2] = '0;
        bus.instr_i = '0; bus.instr_valid_i = 0; bus.redirect_i = 0;
        addi  = {6'd8, 5'd0, 5'd8, 16'd5};
        lw9   = {6'd35, 5'd1, 5'd9, 16'd4};
        lw0   = {6'd35, 5'd1, 5'd0, 16'd4};
        add9  = {6'd0, 5'd9, 5'd2, 5'd10, 5'd0, 6'h20};
        add0  = {6'd0, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
        addi9 = {6'd8, 5'd3, 5'd9, 16'd1};
        jal   = {6'd3, 26'h40};
        jr    = {6'd0, 5'd4, 5'd0, 5'd0, 5'd0, 6'h08};
        ill   = {6'd63, 26'h3ff_ffff};
        @(posedge clk); #1;
        step(32'h0, 0, 0, 1);
        step(32'h0, 0, 0, 1);
        chk("rst_ex_reg_write", bus.ex_reg_write_o, 0);
        chk("rst_wb_wreg", bus.wb_wreg_o, 0);
        chk("rst_stall", bus.stall_o, 0);

        step(addi, 1, 0, 0);
        chk("addi_alu_op", bus.ex_alu_op_o, 3'b001);
        chk("addi_wreg", bus.ex_wreg_o, 8);
        chk("addi_rw", bus.ex_reg_write_o, 1);
        step(32'h0, 0, 0, 0);
        step(32'h0, 0, 0, 0);
        chk("addi_wb_rw", bus.wb_reg_write_o, 1);
        chk("addi_wb_wreg", bus.wb_wreg_o, 8);

        step(lw9, 1, 0, 0);
        step(add9, 1, 0, 0);
`ifdef PCU_HAZARD_EN
        chk("lu_stall", last_stall, 1);
        chk("lu_bubble_rw", bus.ex_reg_write_o, 0);
        chk("lu_bubble_rs", bus.ex_rs_o, 0);
        step(add9, 1, 0, 0);
        chk("lu_stall_clear", last_stall, 0);
`else
        chk("lu_nostall", last_stall, 0);
`endif
        chk("lu_add_rs", bus.ex_rs_o, 9);
        chk("lu_add_wreg", bus.ex_wreg_o, 10);

        step(lw0, 1, 0, 0);
        step(add0, 1, 0, 0);
        chk("lw0_nostall", last_stall, 0);
        step(lw9, 1, 0, 0);
        step(addi9, 1, 0, 0);
        chk("addi_rs_nostall", last_stall, 0);

        step(lw9, 1, 0, 0);
        step(add9, 1, 1, 0);
        chk("flush_stall", last_stall, 0);
        chk("flush_flush", last_flush, 1);
        chk("flush_bubble_rs", bus.ex_rs_o, 0);
        chk("flush_bubble_mr", bus.ex_reg_write_o, 0);

        step(jal, 1, 0, 0);
        chk("jal_wreg", bus.ex_wreg_o, 31);
        step(jr, 1, 0, 0);
        chk("jal_mem_m2r", bus.mem_mem_to_reg_o, 2'b10);
        chk("jr_jr", bus.ex_jr_o, 1);
        chk("jr_rw", bus.ex_reg_write_o, 0);
        step(ill, 1, 0, 0);
        chk("ill_illegal", bus.ex_illegal_o, 1);
        chk("ill_alu_src", bus.ex_alu_src_o, 0);
        chk("ill_alu_op", bus.ex_alu_op_o, 0);
        chk("ill_rw", bus.ex_reg_write_o, 0);

        step(addi, 1, 0, 0);
        step(lw9, 1, 0, 1);
        chk("mrst_ex_wreg", bus.ex_wreg_o, 0);
        chk("mrst_mem_rw", bus.mem_reg_write_o, 0);
        chk("mrst_mem_wreg", bus.mem_wreg_o, 0);
        chk("mrst_wb_rw", bus.wb_reg_write_o, 0);
        chk("mrst_wb_m2r", bus.wb_mem_to_reg_o, 0);

        for (int i = 0; i < 600; i++) begin
            ins = {ops[$urandom_range(0, 14)], pick_reg(), pick_reg(), pick_reg(), 5'($urandom),
                   ($urandom_range(0, 4) == 0) ? 6'h08 : 6'($urandom)};
            step(ins, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage MIPS datapath. Decodes the IF/ID instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and inserts bubbles. Squashes younger instructions when the EX stage redirects the PC. It supersedes the single-cycle combinational decoder: it adds the JR decode, resolves the destination register in ID, and adds stall/flush sequencing.

## Interface
- REG_AW, 5, register-address width
- LINK_REG, 31, destination register index for JAL
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- instr_i  in  32  IF/ID instruction (op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0])
- instr_valid_i  in  1  IF/ID holds a real instruction; 0 decodes as a bubble
- redirect_i  in  1  EX stage resolved a taken branch or jump this cycle
- stall_o  out  1  hold the PC and IF/ID this cycle (combinational)
- flush_o  out  1  squash IF/ID this cycle (combinational; equals redirect_i)
- ex_alu_op_o  out  3  ALU op
- ex_alu_src_o  out  1  ALU operand select
- ex_sign_o  out  1  sign select
- ex_branch_o  out  1  branch
- ex_branch_type_o  out  2  branch type
- ex_jump_o  out  1  jump
- ex_jr_o  out  1  jump-register
- ex_illegal_o  out  1  illegal opcode
- ex_rs_o  out  REG_AW  EX rs, for the forwarding unit
- ex_rt_o  out  REG_AW  EX rt, for the forwarding unit
- ex_wreg_o  out  REG_AW  resolved destination register
- ex_reg_write_o  out  1  EX register write
- mem_read_o  out  1  MEM read
- mem_write_o  out  1  MEM write
- mem_reg_write_o  out  1  MEM register write
- mem_wreg_o  out  REG_AW  MEM destination register
- mem_mem_to_reg_o  out  2  MEM write-back select
- wb_reg_write_o  out  1  WB register write
- wb_wreg_o  out  REG_AW  WB destination register
- wb_mem_to_reg_o  out  2  WB write-back select

## Operation
- Decode encodings:
  - RegDst: 00 = rt, 01 = rd, 10 = LINK_REG.
  - MemtoReg: 00 = ALU, 01 = memory, 10 = PC+4.
  - BranchType: 00 = BEQ, 01 = BGT, 10 = BGEZ, 11 = BNE.
  - alu_src = op[3] | op[5].
- Decode table, per opcode (fields in the order alu_op, sign, others):
  - R-type 000000: alu_op 000, sign 1, RegDst rd, reg_write 1.
  - JR (R-type, funct 001000): jr 1, reg_write 0.
  - ADDI 8: alu_op 001, sign 0, rt, reg_write 1.
  - SLTI 10: alu_op 010, sign 1, rt, reg_write 1.
  - LUI 15: alu_op 011, sign 1, rt, reg_write 1.
  - ORI 13: alu_op 100, sign 0, rt, reg_write 1.
  - BEQ 4 / BNE 5 / BGT 7 / BGEZ 1: alu_op 110, branch 1, matching BranchType.
  - LW 35: alu_op 100, sign 1, rt, reg_write 1, mem_read 1, MemtoReg 01.
  - SW 43: alu_op 100, sign 1, mem_write 1.
  - J 2: alu_op 111, jump 1.
  - JAL 3: alu_op 111, jump 1, reg_write 1, RegDst LINK_REG, MemtoReg 10.
  - Any other opcode: all controls 0, illegal 1.
- Destination register 0 forces reg_write to 0.
- Bubble: all control bits 0 and all register fields 0.
- ID/EX update priority, per cycle: rst_i > redirect_i (bubble) > load-use hazard (bubble) > !instr_valid_i (bubble) > decoded bundle.
- EX/MEM and MEM/WB always shift from the previous stage. Stall and flush never freeze them.
- Load-use hazard (PCU_HAZARD_EN only) is asserted when all of the following hold:
  - ID/EX mem_read = 1;
  - ex_wreg_o != 0;
  - ex_wreg_o matches the ID rs, or matches the ID rt when the ID instruction reads rt (R-type, BEQ, BNE, BGT, SW);
  - instr_valid_i = 1.
- stall_o = hazard & !redirect_i.

## Timing
- Decode-to-ex_* latency is 1 cycle. mem_* follows at 2 cycles, wb_* at 3 cycles.
- stall_o and flush_o are combinational from the current inputs and the ID/EX register contents.
- A load-use hazard stalls exactly 1 cycle. The next cycle holds a bubble in EX, so the hazard clears and the held instruction decodes.
- Simultaneous redirect_i and hazard: flush wins. stall_o = 0, flush_o = 1, and ID/EX is loaded with a bubble.
- Reset, including mid-stream: every output register goes to 0 on the next edge. Combinational outputs follow from the zeroed state; stall_o is 0 after reset.
- No state survives reset, and there is no partial-reset behaviour.

## Configuration
- PCU_HAZARD_EN defined: load-use detection and bubble insertion are active as described above.
- PCU_HAZARD_EN undefined:
  - stall_o is tied to 0 and the comparators are not built;
  - software must schedule NOPs after loads;
  - all other behaviour is identical.

## Test plan
- Reset then ADDI $8,$0,5: ex_alu_op_o = 001, ex_wreg_o = 8, ex_reg_write_o = 1 at cycle 1; wb_reg_write_o = 1 and wb_wreg_o = 8 at cycle 3.
- LW $9 followed by ADD $10,$9,$2 (PCU_HAZARD_EN): stall_o = 1 for exactly one cycle; ex_* shows a bubble; the ADD reaches EX one cycle late with ex_rs_o = 9.
- LW $0 followed by ADD using $0: no stall. LW $9 followed by ADDI $9,$3,1 (reads rs = 3 only): no stall.
- BEQ in EX with redirect_i = 1 while the ID instruction would hazard: flush_o = 1, stall_o = 0, next ex_* = bubble.
- JAL: ex_wreg_o = 31, mem_mem_to_reg_o = 10 two cycles later. JR funct 001000: ex_jr_o = 1, ex_reg_write_o = 0.
- Opcode 63: ex_illegal_o = 1 and all other controls 0. Reset asserted mid-pipeline: every stage register is 0 on the next cycle.
